// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-transfer sequencer: redirects fetch to a taken branch/jump target,
// squashes wrong-path work in ID/EX and holds ID until fetch delivers the target PC.
module branch_redirect_ctrl #(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 2,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic             i_ex_is_jump,
    input  logic             i_ex_taken,
    input  logic [XLEN-1:0]  i_ex_target,
    input  logic             i_if_valid,
    input  logic [XLEN-1:0]  i_if_pc,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic             o_stall,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_redirect_cnt
);

    localparam int FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIRECT,
        S_FLUSH,
        S_WAIT_TGT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [XLEN-1:0]  r_tgt, w_tgt_nxt;
    logic [FC_W-1:0]  r_fcnt, w_fcnt_nxt;
    logic [TC_W-1:0]  r_tcnt, w_tcnt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic w_event;
    logic w_match;
    logic w_flushing;
    logic w_waiting;

    // A jump is a transfer regardless of the branch flag; branches only when taken.
    assign w_event = i_ex_valid & (i_ex_is_jump | (i_ex_is_branch & i_ex_taken));
    assign w_match = i_if_valid & (i_if_pc == r_tgt);

    // NOTE: every next-state variable gets its hold value first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_fcnt_nxt  = r_fcnt;
        w_tcnt_nxt  = r_tcnt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    w_tgt_nxt   = {i_ex_target[XLEN-1:1], 1'b0};
                    w_state_nxt = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                w_fcnt_nxt  = FC_W'(FLUSH_DEPTH - 1);
                w_tcnt_nxt  = '0;
                w_state_nxt = (FLUSH_DEPTH > 1) ? S_FLUSH : S_WAIT_TGT;
            end
            S_FLUSH: begin
                w_fcnt_nxt = r_fcnt - 1'b1;
                if (r_fcnt <= FC_W'(1)) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_WAIT_TGT;
                end
            end
            S_WAIT_TGT: begin
                // A matching fetch wins over a timeout landing on the same cycle.
                if (w_match) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == TC_W'(TIMEOUT - 1)) begin
                    w_state_nxt = S_REDIRECT;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_tgt   <= '0;
            r_fcnt  <= '0;
            r_tcnt  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs decode from state; the fetch match is the only input reaching them,
    // so the instruction arriving at the target is let through ID unflushed.
    assign w_flushing     = (r_state == S_REDIRECT) | (r_state == S_FLUSH);
    assign w_waiting      = (r_state == S_WAIT_TGT);
    assign o_redirect     = (r_state == S_REDIRECT);
    assign o_redirect_pc  = r_tgt;
    assign o_flush_ex     = w_flushing;
    assign o_flush_id     = w_flushing | (w_waiting & ~w_match);
    assign o_stall        = w_flushing | (w_waiting & ~w_match);
    assign o_busy         = (r_state != S_IDLE);
    assign o_redirect_cnt = r_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: elapsed-cycle reference model with a
// per-cycle compare, directed literal checks, and a small-counter instance for saturation.
`timescale 1ns/1ps
module tb_branch_redirect_ctrl;

    localparam int FD      = 2;
    localparam int TO      = 15;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken;
    logic [31:0] ex_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        redirect, flush_id, flush_ex, stall, busy;
    logic [31:0] redirect_pc;
    logic [15:0] redirect_cnt;

    logic        s_ex_valid, s_ex_is_jump;
    logic [31:0] s_ex_target;
    logic        s_redirect, s_flush_id, s_flush_ex, s_stall, s_busy;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_DEPTH(FD), .TIMEOUT(TO), .CNT_W(CW)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_ex_valid(ex_valid), .i_ex_is_branch(ex_is_branch), .i_ex_is_jump(ex_is_jump),
        .i_ex_taken(ex_taken), .i_ex_target(ex_target),
        .i_if_valid(if_valid), .i_if_pc(if_pc),
        .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_flush_id(flush_id),
        .o_flush_ex(flush_ex), .o_stall(stall), .o_busy(busy), .o_redirect_cnt(redirect_cnt)
    );

    // Minimal flush, one-cycle timeout and a 4-bit counter: redirects every other cycle.
    branch_redirect_ctrl #(.XLEN(32), .FLUSH_DEPTH(1), .TIMEOUT(1), .CNT_W(4)) u_sat (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_ex_valid(s_ex_valid), .i_ex_is_branch(1'b0), .i_ex_is_jump(s_ex_is_jump),
        .i_ex_taken(1'b0), .i_ex_target(s_ex_target),
        .i_if_valid(1'b0), .i_if_pc(32'h0),
        .o_redirect(s_redirect), .o_redirect_pc(s_redirect_pc), .o_flush_id(s_flush_id),
        .o_flush_ex(s_flush_ex), .o_stall(s_stall), .o_busy(s_busy), .o_redirect_cnt(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sequence is "k cycles since the last redirect pulse".
    // k < FD flushes both stages; k >= FD waits for the target; the wait lasts TO cycles.
    bit          m_busy = 1'b0;
    int          m_k = 0;
    logic [31:0] m_tgt = 32'h0;
    int          m_cnt = 0;

    function automatic bit m_match();
        return m_busy && (m_k >= FD) && if_valid && (if_pc == m_tgt);
    endfunction

    always @(posedge i_clk) begin
        if (!i_reset) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_tgt  <= 32'h0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (ex_valid && (ex_is_jump || (ex_is_branch && ex_taken))) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_tgt  <= ex_target & ~32'h1;
            end
        end else begin
            if (m_k == 0) m_cnt <= (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
            if (m_match())            m_busy <= 1'b0;
            else if (m_k == FD+TO-1)  m_k <= 0;
            else                      m_k <= m_k + 1;
        end
    end

    always @(negedge i_clk) begin : compare
        logic        e_red, e_fid, e_fex, e_busy;
        logic [31:0] e_pc, e_cnt;
        if (!i_reset) begin
            e_red = 1'b0; e_fid = 1'b0; e_fex = 1'b0; e_busy = 1'b0;
            e_pc = 32'h0; e_cnt = 32'h0;
        end else begin
            e_busy = m_busy;
            e_red  = m_busy && (m_k == 0);
            e_fex  = m_busy && (m_k < FD);
            e_fid  = m_busy && !m_match();
            e_pc   = m_tgt;
            e_cnt  = 32'(m_cnt);
        end
        check("m_redirect", 32'(redirect), 32'(e_red));
        check("m_flush_ex", 32'(flush_ex), 32'(e_fex));
        check("m_flush_id", 32'(flush_id), 32'(e_fid));
        check("m_stall",    32'(stall),    32'(e_fid));
        check("m_busy",     32'(busy),     32'(e_busy));
        check("m_pc",       redirect_pc,   e_pc);
        check("m_cnt",      32'(redirect_cnt), e_cnt);
    end

    task automatic set_idle();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_target = 32'h0; if_valid = 1'b0; if_pc = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int  gap;
        bit  seen;
        int  pulses;
        set_idle();
        s_ex_valid = 1'b0; s_ex_is_jump = 1'b0; s_ex_target = 32'h0;
        i_reset = 1'b0;
        repeat (2) next_cycle();
        @(negedge i_clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cnt", 32'(redirect_cnt), 32'h0);
        next_cycle();
        i_reset = 1'b1;

        // Not-taken BNE: no redirect, counter untouched.
        next_cycle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b0; ex_target = 32'h200;
        next_cycle();
        set_idle();
        @(negedge i_clk);
        check("t3_busy", 32'(busy), 32'h0);
        check("t3_redirect", 32'(redirect), 32'h0);
        check("t3_cnt", 32'(redirect_cnt), 32'h0);

        // Taken BEQ to 0x104: pulse, one FLUSH cycle, wait, release on matching fetch.
        next_cycle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h104;
        next_cycle();
        set_idle();
        @(negedge i_clk);
        check("t2_redirect", 32'(redirect), 32'h1);
        check("t2_pc", redirect_pc, 32'h104);
        check("t2_flush_ex0", 32'(flush_ex), 32'h1);
        next_cycle();
        @(negedge i_clk);
        check("t2_redirect_off", 32'(redirect), 32'h0);
        check("t2_flush_ex1", 32'(flush_ex), 32'h1);
        check("t2_cnt1", 32'(redirect_cnt), 32'h1);
        next_cycle();
        @(negedge i_clk);
        check("t2_wait_fex", 32'(flush_ex), 32'h0);
        check("t2_wait_fid", 32'(flush_id), 32'h1);
        check("t2_wait_stall", 32'(stall), 32'h1);
        next_cycle();
        if_valid = 1'b1; if_pc = 32'h104;
        @(negedge i_clk);
        check("t2_match_fid", 32'(flush_id), 32'h0);
        check("t2_match_stall", 32'(stall), 32'h0);
        check("t2_match_busy", 32'(busy), 32'h1);
        next_cycle();
        set_idle();
        @(negedge i_clk);
        check("t2_idle", 32'(busy), 32'h0);
        check("t2_cnt", 32'(redirect_cnt), 32'h1);

        // Reset dropped mid-FLUSH: outputs clear in the same cycle.
        next_cycle();
        ex_valid = 1'b1; ex_is_jump = 1'b1; ex_target = 32'h300;
        next_cycle();
        set_idle();
        @(negedge i_clk);
        check("t1_redirect", 32'(redirect), 32'h1);
        next_cycle();
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_fid", 32'(flush_id), 32'h0);
        check("t1_fex", 32'(flush_ex), 32'h0);
        check("t1_stall", 32'(stall), 32'h0);
        check("t1_pc", redirect_pc, 32'h0);
        check("t1_cnt", 32'(redirect_cnt), 32'h0);
        next_cycle();
        i_reset = 1'b1;
        @(negedge i_clk);
        check("t1_after", 32'(busy), 32'h0);

        // JALR to 0x2003 with branch flag also set; no fetch match -> re-issue after FD+TO.
        next_cycle();
        ex_valid = 1'b1; ex_is_jump = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b0;
        ex_target = 32'h2003;
        next_cycle();
        set_idle();
        @(negedge i_clk);
        check("t4_redirect", 32'(redirect), 32'h1);
        check("t4_pc", redirect_pc, 32'h2002);
        gap = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            next_cycle();
            @(negedge i_clk);
            if (redirect) begin
                seen = 1'b1;
                gap = i;
            end
        end
        check("t5_seen", 32'(seen), 32'h1);
        check("t5_gap", 32'(gap), 32'd17);
        check("t5_pc", redirect_pc, 32'h2002);
        next_cycle();
        @(negedge i_clk);
        check("t5_cnt", 32'(redirect_cnt), 32'h2);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if_valid = 1'b1; if_pc = 32'h2002;
            @(negedge i_clk);
            if (!busy) break;
        end
        check("t5_idle", 32'(busy), 32'h0);

        // Randomized traffic, occasional reset pulses; the compare process does the checking.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            i_reset      = ($urandom_range(0, 499) != 0);
            ex_valid     = ($urandom_range(0, 1) == 1);
            ex_is_branch = ($urandom_range(0, 1) == 1);
            ex_is_jump   = ($urandom_range(0, 3) == 0);
            ex_taken     = ($urandom_range(0, 1) == 1);
            ex_target    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
            if_valid     = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0)     if_pc = m_tgt;
            else if ($urandom_range(0, 3) == 0) if_pc = m_tgt | 32'h1;
            else                                if_pc = 32'($urandom_range(0, 63));
        end
        next_cycle();
        set_idle();
        i_reset = 1'b1;
        next_cycle();
        next_cycle();

        // Saturation on the 4-bit instance: counter climbs to 15 and holds.
        s_ex_valid = 1'b1; s_ex_is_jump = 1'b1; s_ex_target = 32'h41;
        next_cycle();
        s_ex_valid = 1'b0; s_ex_is_jump = 1'b0; s_ex_target = 32'h0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (s_redirect) begin
                check("t6_cnt", 32'(s_cnt), 32'((pulses > 15) ? 15 : pulses));
                check("t6_pc", s_redirect_pc, 32'h40);
                pulses++;
            end
            next_cycle();
        end
        @(negedge i_clk);
        check("t6_pulses", 32'(pulses >= 20), 32'h1);
        check("t6_final", 32'(s_cnt), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
